// File: rtl/icache_nblock.sv
// Direct-mapped instruction cache: SETS lines of BLOCK_WORDS words, burst-filled from memory.
// Hits return in the same cycle; a miss costs BLOCK_WORDS+1 cycles plus one per iwait cycle.
// Memory backpressure (iwait=1) holds iREN/iaddr stable until the word is accepted.
module icache_nblock #(
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 2,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  input  logic             inv,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int OFF   = $clog2(BLOCK_WORDS);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - OFF - IDX;
  localparam int LW    = OFF + IDX;            // bits selecting one word in the whole cache
  localparam int CW    = (OFF > 0) ? OFF : 1;  // word counter width, at least one bit

  localparam logic [29:0]   OFF_MASK = 30'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] LAST_W   = CW'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic [29:0]        fill_base_q, fill_base_d;  // word address of the line being filled, offset zeroed
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pend_q, pend_d;            // invalidate requested while a fill was running
  logic [SETS-1:0]    valid_q, valid_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [31:0]        data_q [SETS*BLOCK_WORDS];

  logic [29:0]        waddr;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic [IDX-1:0]     req_idx, fill_idx;
  logic [LW-1:0]      req_sel, wr_sel;
  logic               lookup_hit;
  logic               wr_en, wr_last;
  logic               unused_byte_off;

  // Byte offset carries no information for a word-aligned fetch.
  assign unused_byte_off = &{1'b0, imemaddr[1:0]};

  assign waddr      = imemaddr[31:2];
  assign req_tag    = waddr[29 -: TAG_W];
  assign req_idx    = waddr[OFF +: IDX];
  assign req_sel    = waddr[LW-1:0];
  assign fill_tag   = fill_base_q[29 -: TAG_W];
  assign fill_idx   = fill_base_q[OFF +: IDX];
  assign wr_sel     = fill_base_q[LW-1:0] | LW'(cnt_q);
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Next-state, outputs and counter updates for the lookup/fill controller.
  always_comb begin
    state_d     = state_q;
    fill_base_d = fill_base_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    valid_d     = valid_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    wr_en       = 1'b0;
    wr_last     = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit      = 1'b1;
            imemload  = data_q[req_sel];
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            fill_base_d = waddr & ~OFF_MASK;
            cnt_d       = '0;
            state_d     = FILL;
            miss_cnt_d  = miss_cnt_q + CNT_W'(1);
          end
        end
        // The lookup above still sees the old valid bits this cycle.
        if (inv) valid_d = '0;
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {fill_base_q | 30'(cnt_q), 2'b00};
        if (inv) pend_d = 1'b1;
        if (!iwait) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_W) begin
            wr_last           = 1'b1;
            state_d           = IDLE;
            valid_d[fill_idx] = 1'b1;
            // A deferred invalidate also wipes the line that just completed.
            if (pend_q || inv) begin
              valid_d = '0;
              pend_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, valid bits and counters; reset returns to an empty cache.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      fill_base_q <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      valid_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_base_q <= fill_base_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      valid_q     <= valid_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Line payload: each accepted word lands in place; the tag is written with the last word.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      data_q[wr_sel] <= iload;
      if (wr_last) tag_q[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_nblock.sv
// Bench for icache_nblock: random and directed fetches checked against a line-level cache model.
// Expected data/addresses are queued at issue time and consumed by an independent monitor.
// Memory is a pure function of address, with selectable wait-state patterns.
module tb_icache_nblock;

  localparam int SETS = 16;
  localparam int BW   = 2;
  localparam int CW   = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          imemREN = 1'b0;
  logic [31:0]   imemaddr = '0;
  logic          inv = 1'b0;
  logic          ihit;
  logic [31:0]   imemload;
  logic          iREN;
  logic [31:0]   iaddr;
  logic          iwait = 1'b0;
  logic [31:0]   iload;
  logic [CW-1:0] hit_count, miss_count;

  icache_nblock #(.SETS(SETS), .BLOCK_WORDS(BW), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .inv(inv),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
    .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction
  assign iload = memf(iaddr);

  int vecs = 0;
  int errs = 0;
  int wait_mode = 0;  // 0: no waits, 1: random waits, 2: three wait cycles per word
  int wcnt = 0;

  // Reference model: per-line valid/tag plus event counts.
  bit          mvalid [SETS];
  logic [31:0] mtag   [SETS];
  int          mhits = 0;
  int          mmisses = 0;

  logic [31:0] exp_data_q [$];
  logic [31:0] exp_addr_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
  endtask

  // Memory wait-state generator, driven just after each rising edge.
  initial forever begin
    @(posedge CLK);
    #1;
    if (iREN && wait_mode == 2) begin
      iwait = (wcnt < 3);
      wcnt  = (wcnt == 3) ? 0 : wcnt + 1;
    end else if (iREN && wait_mode == 1) begin
      iwait = ($urandom_range(0, 99) < 30);
    end else begin
      iwait = 1'b0;
      wcnt  = 0;
    end
  end

  // Monitor: consume expected hit data and accepted memory addresses.
  always @(negedge CLK) begin
    if (nRST) begin
      if (ihit) begin
        if (exp_data_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL unexpected_ihit: got ihit=1 addr %h expected no hit", imemaddr);
        end else check("imemload", imemload, exp_data_q.pop_front());
      end else check("imemload_nohit", imemload, 32'h0);
      if (iREN && !iwait) begin
        if (exp_addr_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL unexpected_fill_word: got iaddr %h expected no memory read", iaddr);
        end else check("iaddr", iaddr, exp_addr_q.pop_front());
      end
      if (!iREN) check("iaddr_idle", iaddr, 32'h0);
    end
  end

  // One fetch held until ihit. inv_at: -1 none, 0 in the lookup cycle, k>=1 in fill cycle k.
  task automatic fetch(input logic [31:0] a, input int inv_at_in);
    int inv_at = inv_at_in;
    int idx = int'((a >> 3) % SETS);
    logic [31:0] tag = a >> 7;
    logic [31:0] base = a & ~32'h7;
    bit hit0 = mvalid[idx] && (mtag[idx] == tag);
    int nfill, n, waits;
    if (hit0 && inv_at >= 1) inv_at = -1;
    nfill = hit0 ? 0 : ((inv_at >= 1) ? 2 : 1);
    for (int f = 0; f < nfill; f++)
      for (int w = 0; w < BW; w++) exp_addr_q.push_back(base + 32'(4 * w));
    exp_data_q.push_back(memf(a & ~32'h3));
    mmisses += nfill;
    mhits++;
    if (inv_at >= 0) model_clear();
    if (nfill > 0) begin mvalid[idx] = 1'b1; mtag[idx] = tag; end

    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = a; inv = (inv_at == 0);
    n = 0; waits = 0;
    forever begin
      @(negedge CLK);
      if (ihit) break;
      if (iREN && iwait) waits++;
      if (n > 200) begin
        vecs++; errs++;
        $display("FAIL fetch_timeout: got no ihit after %0d cycles expected ihit for %h", n, a);
        break;
      end
      @(posedge CLK); #1;
      n++;
      inv = (n == inv_at);
    end
    check("hit_latency", 32'(n), 32'(nfill * (BW + 1) + waits));
    @(posedge CLK); #1;
    imemREN = 1'b0; inv = 1'b0; imemaddr = $urandom;
    @(negedge CLK);
    check("hit_count", 32'(hit_count), 32'(mhits % (1 << CW)));
    check("miss_count", 32'(miss_count), 32'(mmisses % (1 << CW)));
  endtask

  task automatic do_inv();
    @(posedge CLK); #1;
    imemREN = 1'b0; inv = 1'b1;
    @(posedge CLK); #1;
    inv = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    #12;
    @(negedge CLK);
    check("rst_ihit", 32'(ihit), 0);
    check("rst_imemload", imemload, 0);
    check("rst_iREN", 32'(iREN), 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_hit_count", 32'(hit_count), 0);
    check("rst_miss_count", 32'(miss_count), 0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // First miss and hits in the filled line.
    fetch(32'h100, -1);
    fetch(32'h104, -1);
    fetch(32'h100, -1);
    // Conflict eviction on index 0.
    do_inv();
    fetch(32'h100, -1);
    fetch(32'h180, -1);
    fetch(32'h100, -1);
    // Three wait cycles per word.
    wait_mode = 2;
    fetch(32'h300, -1);
    wait_mode = 0;
    // Invalidate during a fill, then during idle.
    fetch(32'h200, 1);
    fetch(32'h200, -1);
    fetch(32'h108, -1);
    fetch(32'h108, 0);
    fetch(32'h108, -1);
    fetch(32'h10C, -1);
    do_inv();
    fetch(32'h10C, -1);
    // Counter wrap: 17 hits.
    for (int i = 0; i < 17; i++) fetch(32'h108, -1);

    // Reset in the middle of a fill.
    do_inv();
    @(posedge CLK); #1;
    exp_addr_q.push_back(32'h240);
    imemREN = 1'b1; imemaddr = 32'h240;
    @(posedge CLK); #1;
    imemREN = 1'b0;
    @(negedge CLK); #1;
    nRST = 1'b0;
    @(negedge CLK);
    check("midrst_iREN", 32'(iREN), 0);
    check("midrst_iaddr", iaddr, 0);
    check("midrst_ihit", 32'(ihit), 0);
    check("midrst_hit_count", 32'(hit_count), 0);
    check("midrst_miss_count", 32'(miss_count), 0);
    check("midrst_pending_words", 32'(exp_addr_q.size()), 0);
    exp_addr_q.delete();
    model_clear();
    mhits = 0; mmisses = 0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    fetch(32'h240, -1);

    // Randomized traffic over a small address pool to mix hits, conflicts and waits.
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 19);
      logic [31:0] a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 127)) << 2);
      wait_mode = $urandom_range(0, 1);
      if (r == 0) do_inv();
      else fetch(a, (r == 1) ? 0 : ((r == 2) ? 1 : -1));
    end
    wait_mode = 0;

    check("leftover_data", 32'(exp_data_q.size()), 0);
    check("leftover_addr", 32'(exp_addr_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/icache_nblock.md
# icache_nblock

Parametrised direct-mapped instruction cache that sits between the datapath fetch port and the memory controller's instruction channel. It replaces the fixed 16-entry, one-word-per-block icache with configurable set count and multi-word blocks, filled in bursts. It adds registered storage, a global invalidate, and hit/miss performance counters.

## Interface
- SETS, 16: number of lines; power of 2, ≥2.
- BLOCK_WORDS, 2: 32-bit words per line; power of 2, ≥1.
- CNT_W, 32: width of each performance counter.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- inv  in  1  invalidate all lines (single-cycle pulse).
- ihit  out  1  imemload valid this cycle.
- imemload  out  32  fetched instruction.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; a word is accepted on a cycle where iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_count  out  CNT_W  lookup hits since reset.
- miss_count  out  CNT_W  misses since reset.

## Operation
- Address split:
  - [1:0] byte offset.
  - OFF=log2(BLOCK_WORDS) word-offset bits at [OFF+1:2].
  - IDX=log2(SETS) index bits next above those.
  - Tag = remaining upper bits, width 30-OFF-IDX.
- Line storage: valid bit, tag, BLOCK_WORDS data words. All flops; no combinational writes to storage.
- States: IDLE, FILL.
- IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==addr tag).
  - ihit=hit; imemload=selected word when hit, else 0.
  - On imemREN & !hit: latch fill tag and index, clear word counter, go to FILL.
- FILL:
  - iREN=1; iaddr={fill tag, fill index, word counter, 2'b00}.
  - Words are fetched in order 0..BLOCK_WORDS-1, not critical-word-first.
  - On each accepted word: write iload into data[fill index][counter], then increment the counter.
  - On the last accepted word: set valid and tag, return to IDLE.
  - ihit=0 and imemload=0 throughout FILL. Changes to imemaddr during FILL do not affect the fill in progress.
- Counters:
  - hit_count increments on each IDLE cycle with hit=1.
  - miss_count increments on each IDLE→FILL transition.
  - Both wrap modulo 2^CNT_W; neither saturates.
- inv:
  - In IDLE: all valid bits clear at the next edge. A lookup in that same cycle still evaluates the old valid bits.
  - In FILL: a pending flag is set. The fill runs to completion; at completion all valid bits clear, including the line just filled, and the pending flag clears.
- imemREN=0 in IDLE: ihit=0, imemload=0, no counter change, no state change.

## Timing
- Reset values:
  - state IDLE, all valid=0, pending inv=0.
  - hit_count=0, miss_count=0.
  - iREN=0, iaddr=0, ihit=0, imemload=0.
- Hit latency: 0 cycles. ihit and imemload are combinational from address and storage in the same cycle.
- Miss with zero-wait memory:
  - cycle 0: miss detected in IDLE.
  - cycles 1..BLOCK_WORDS: one word accepted per cycle.
  - cycle BLOCK_WORDS+1: hit.
  - Each iwait=1 cycle adds one cycle.
- iREN and iaddr stay stable while iwait=1. iaddr=0 whenever iREN=0.
- Reset asserted mid-FILL: immediate return to the reset state. The partially filled line stays invalid.
- Parameter edge case BLOCK_WORDS=1: OFF=0, and the fill is a single transaction.

## Test plan
- Reset, then imemREN=1 with addr 0x100 (SETS=16, BLOCK_WORDS=2), memory with zero wait:
  - iaddr must be 0x100 then 0x104 on consecutive cycles.
  - ihit=1 on cycle 3 with data from 0x100.
  - miss_count=1.
- After that fill, fetch 0x104: ihit in the same cycle with data from 0x104, hit_count increments, iREN stays 0.
- Conflict eviction: fetch 0x100, then 0x180 (same index 0, different tag), then 0x100.
  - Three misses; miss_count=3.
  - Each fetch refills the line.
- iwait held high 3 cycles per word during a fill: iaddr holds each word address until accepted; ihit first asserts on cycle 9.
- inv pulse mid-FILL on 0x200: fill completes, then the next fetch of 0x200 misses again; an inv pulse in IDLE makes a cached 0x100 miss on the next lookup.
- CNT_W=4: issue 17 hits; hit_count must read 1 (wrap).
